led_bank_arbiter: RTL and testbench
===================================

// Module: led_bank_arbiter
// PURPOSE
// - Round-robin arbiter that shares the single BITS-wide LED bank between NREQ
//   pattern sources (counters, blinkers, status displays).
// - Each source requests the bank. The winner drives the LEDs for a time slice
//   of 2^LOG2SLICE clk_25mhz cycles before a contending source takes over.
// - Sits between the pattern generators and the board LED pins.
// PARAMETERS
// - NREQ       4   number of requesters, >= 2
// - BITS       5   LED bank width
// - LOG2SLICE  21  slice length is 2^LOG2SLICE cycles (~84 ms at 25 MHz)
// PORTS
// - clk_25mhz  in   1          system clock, all logic on its rising edge
// - rst        in   1          asynchronous reset, active-high
// - req        in   NREQ       req[i] high = source i wants the LED bank
// - led_in     in   NREQ*BITS  pattern of source i on led_in[i*BITS +: BITS]
// - grant      out  NREQ       one-hot owner, registered; all-zero = no owner
// - led        out  BITS       registered LED drive
// - busy       out  1          high while state is GRANT or HANDOFF
// BEHAVIOUR
// - Reset (asynchronous, takes effect immediately without a clock edge):
//   - state = IDLE, grant = 0, led = 0, busy = 0.
//   - Slice counter = 0; last-owner pointer = NREQ-1, so req[0] wins first.
// - FSM states: IDLE, GRANT, HANDOFF.
// - IDLE:
//   - led <= 0.
//   - Any req sampled high -> winner selected, grant <= onehot(winner),
//     state <= GRANT, slice counter <= 0.
//   - Result: grant rises on the same edge that first samples req.
// - Winner selection: first set req bit scanning from (pointer+1) mod NREQ
//   upward with wrap. Pointer <= winner when the grant is issued.
// - GRANT:
//   - led <= led_in slice of the owner every cycle, so led follows led_in with
//     1-cycle latency.
//   - Slice counter (LOG2SLICE bits) increments every cycle.
//   - Owner req low -> HANDOFF on the next edge. This takes priority over
//     slice expiry when both happen in the same cycle.
//   - Counter == 2^LOG2SLICE-1 and another req is high -> HANDOFF. The owner
//     therefore holds exactly 2^LOG2SLICE cycles when contended.
//   - Counter == 2^LOG2SLICE-1 and no other req -> stay in GRANT; the counter
//     wraps to 0 (slice renewed with no gap and no grant glitch).
// - HANDOFF (exactly 1 cycle):
//   - grant = 0, led holds its last value, busy = 1.
//   - Arbitration runs as in IDLE, using req sampled in this cycle. The
//     previous owner is eligible only if no other source requests.
//   - Any req high -> GRANT with the counter cleared. None high -> IDLE; led
//     is cleared on the next edge.
// - Invariants:
//   - grant is always one-hot or zero.
//   - grant is never non-zero in IDLE or HANDOFF.
//   - Out-of-range pointer values are impossible by construction.
// - req bits of non-owners may toggle freely; only their value at an
//   arbitration edge matters.
// TESTING (bench uses LOG2SLICE=3, i.e. 8-cycle slice)
// - Reset: assert rst mid-cycle with grant=0010 -> grant, led and busy read
//   0 before the next clock edge. After release, req=1111 -> grant=0001.
// - Solo owner: req=0001, led_in[4:0]=5'h15 held 40 cycles -> grant=0001
//   continuously (no gap at wrap). led=5'h15 from the 2nd edge. busy=1.
// - Contention: req=0101 constant -> grant 0001 x8, 0000 x1, 0100 x8,
//   0000 x1, 0001 ... and led alternates between source 0 and source 2.
// - Early release: owner 1 drops req on slice cycle 3 while req=1000 is
//   pending -> grant=0000 next edge, grant=1000 the edge after.
// - Release plus expiry: owner drop coincides with counter=7 and no other req
//   -> HANDOFF, then IDLE. led=0 one edge after IDLE is entered. busy=0.
// - Fairness: req=1111 held 4 slices -> grant order 0001, 0010, 0100, 1000,
//   with every slice exactly 8 cycles long.

Source files
------------

// File: rtl/led_bank_arbiter_if.sv
// led_bank_arbiter_if: request/pattern inputs and grant/LED outputs of the LED bank arbiter
interface led_bank_arbiter_if #(
    parameter int NREQ = 4,
    parameter int BITS = 5
);
    logic [NREQ-1:0]      req;
    logic [NREQ*BITS-1:0] led_in;
    logic [NREQ-1:0]      grant;
    logic [BITS-1:0]      led;
    logic                 busy;
    modport master (output req, led_in, input grant, led, busy);
    modport slave (input req, led_in, output grant, led, busy);
endinterface

// File: rtl/led_bank_arbiter.sv
// led_bank_arbiter: round-robin time-sliced sharing of one LED bank between NREQ pattern sources
module led_bank_arbiter #(
    parameter int NREQ      = 4,
    parameter int BITS      = 5,
    parameter int LOG2SLICE = 21
) (
    input logic              clk_25mhz,
    input logic              rst,
    led_bank_arbiter_if.slave bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    typedef enum logic [1:0] {IDLE, GRANT, HANDOFF} state_t;
    state_t               state;
    logic [PW-1:0]        ptr;
    logic [LOG2SLICE-1:0] cnt;
    logic [PW-1:0]        win;
    logic                 any;
    logic                 others;
    // ptr doubles as the owner index while in GRANT
    always_comb begin
        win = ptr;
        for (int k = NREQ; k >= 1; k--)
            if (bus.req[(int'(ptr) + k) % NREQ]) win = PW'((int'(ptr) + k) % NREQ);
    end
    assign any    = |bus.req;
    assign others = |(bus.req & ~(NREQ'(1) << ptr));
    always_ff @(posedge clk_25mhz or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= PW'(NREQ - 1);
            cnt       <= '0;
            bus.grant <= '0;
            bus.led   <= '0;
            bus.busy  <= 1'b0;
        end else begin
            case (state)
                GRANT: begin
                    bus.led <= bus.led_in[int'(ptr)*BITS +: BITS];
                    cnt     <= cnt + 1'b1;
                    if (!bus.req[ptr] || (&cnt && others)) begin
                        state     <= HANDOFF;
                        bus.grant <= '0;
                    end
                end
                default: begin
                    if (state == IDLE) bus.led <= '0;
                    if (any) begin
                        state     <= GRANT;
                        ptr       <= win;
                        cnt       <= '0;
                        bus.grant <= NREQ'(1) << win;
                        bus.busy  <= 1'b1;
                    end else begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_led_bank_arbiter.sv
// tb_led_bank_arbiter: table vectors, directed corner sequences and random traffic against an ownership model
module tb_led_bank_arbiter;
    localparam int NREQ = 4, BITS = 5, L2S = 3, SLICE = 8;
    localparam logic [NREQ*BITS-1:0] PAT = {5'h1C, 5'h03, 5'h0A, 5'h15};
    typedef struct {
        logic [NREQ-1:0] req;
        logic [NREQ-1:0] grant;
        logic [BITS-1:0] led;
        logic            busy;
    } vec_t;
    logic clk_25mhz = 1'b0;
    logic rst = 1'b1;
    int vectors = 0, miscompares = 0;
    int m_owner, m_age, m_last;
    bit m_gap;
    logic [BITS-1:0] m_led;
    vec_t tbl[12];
    always #5 clk_25mhz = ~clk_25mhz;
    led_bank_arbiter_if #(.NREQ(NREQ), .BITS(BITS)) bus ();
    led_bank_arbiter #(.NREQ(NREQ), .BITS(BITS), .LOG2SLICE(L2S)) dut (
        .clk_25mhz(clk_25mhz),
        .rst(rst),
        .bus(bus)
    );
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask
    function automatic int pick(input logic [NREQ-1:0] r);
        for (int k = 1; k <= NREQ; k++)
            if (r[(m_last + k) % NREQ]) return (m_last + k) % NREQ;
        return -1;
    endfunction
    // Ownership view: who holds the bank, for how long, and whether a one-cycle gap is running
    task automatic model_step(input logic [NREQ-1:0] r, input logic [NREQ*BITS-1:0] li);
        int w;
        if (m_owner >= 0) begin
            m_led = li[m_owner*BITS +: BITS];
            m_age++;
            if (!r[m_owner] || (m_age % SLICE == 0 && (r & ~(NREQ'(1) << m_owner)) != 0)) begin
                m_owner = -1;
                m_gap   = 1'b1;
            end
        end else begin
            w = pick(r);
            if (!m_gap) m_led = '0;
            m_gap = 1'b0;
            if (w >= 0) begin
                m_owner = w;
                m_age   = 0;
                m_last  = w;
            end
        end
    endtask
    task automatic cycle(input logic [NREQ-1:0] r, input logic [NREQ*BITS-1:0] li);
        bus.req    = r;
        bus.led_in = li;
        @(posedge clk_25mhz);
        model_step(r, li);
        #1;
        check("grant", 32'(bus.grant), (m_owner >= 0) ? 32'(1) << m_owner : 32'd0);
        check("led", 32'(bus.led), 32'(m_led));
        check("busy", 32'(bus.busy), 32'(m_owner >= 0 || m_gap));
    endtask
    task automatic do_reset();
        rst     = 1'b1;
        m_owner = -1;
        m_gap   = 1'b0;
        m_age   = 0;
        m_last  = NREQ - 1;
        m_led   = '0;
        #1;
        check("rst_grant", 32'(bus.grant), 32'd0);
        check("rst_led", 32'(bus.led), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        @(negedge clk_25mhz);
        rst = 1'b0;
    endtask
    initial begin
        logic [NREQ-1:0] r;
        tbl[0]  = '{4'b0000, 4'b0000, 5'h00, 1'b0};
        tbl[1]  = '{4'b0010, 4'b0010, 5'h00, 1'b1};
        tbl[2]  = '{4'b0010, 4'b0010, 5'h0A, 1'b1};
        tbl[3]  = '{4'b1010, 4'b0010, 5'h0A, 1'b1};
        tbl[4]  = '{4'b1000, 4'b0000, 5'h0A, 1'b1};
        tbl[5]  = '{4'b1000, 4'b1000, 5'h0A, 1'b1};
        tbl[6]  = '{4'b1000, 4'b1000, 5'h1C, 1'b1};
        tbl[7]  = '{4'b0000, 4'b0000, 5'h1C, 1'b1};
        tbl[8]  = '{4'b0000, 4'b0000, 5'h1C, 1'b0};
        tbl[9]  = '{4'b0000, 4'b0000, 5'h00, 1'b0};
        tbl[10] = '{4'b0001, 4'b0001, 5'h00, 1'b1};
        tbl[11] = '{4'b0101, 4'b0001, 5'h15, 1'b1};
        bus.req    = '0;
        bus.led_in = PAT;
        do_reset();
        foreach (tbl[i]) begin
            cycle(tbl[i].req, PAT);
            check("tbl_grant", 32'(bus.grant), 32'(tbl[i].grant));
            check("tbl_led", 32'(bus.led), 32'(tbl[i].led));
            check("tbl_busy", 32'(bus.busy), 32'(tbl[i].busy));
        end
        cycle(4'b0010, PAT);
        cycle(4'b0010, PAT);
        check("pre_rst_grant", 32'(bus.grant), 32'b0010);
        #3;
        do_reset();
        cycle(4'b1111, PAT);
        check("post_rst_grant", 32'(bus.grant), 32'b0001);
        do_reset();
        for (int t = 0; t < 40; t++) begin
            cycle(4'b0001, PAT);
            check("solo_grant", 32'(bus.grant), 32'b0001);
            check("solo_led", 32'(bus.led), (t >= 1) ? 32'h15 : 32'h0);
            check("solo_busy", 32'(bus.busy), 32'd1);
        end
        do_reset();
        for (int t = 0; t < 36; t++) begin
            cycle(4'b0101, PAT);
            check("cont_grant", 32'(bus.grant),
                  (t % 9 == 8) ? 32'd0 : ((t / 9) % 2 == 0 ? 32'b0001 : 32'b0100));
        end
        do_reset();
        for (int t = 0; t < 8; t++) cycle(4'b0001, PAT);
        cycle(4'b0000, PAT);
        check("exp_handoff_grant", 32'(bus.grant), 32'd0);
        check("exp_handoff_busy", 32'(bus.busy), 32'd1);
        cycle(4'b0000, PAT);
        check("exp_idle_busy", 32'(bus.busy), 32'd0);
        check("exp_idle_led", 32'(bus.led), 32'h15);
        cycle(4'b0000, PAT);
        check("exp_led_clear", 32'(bus.led), 32'd0);
        do_reset();
        for (int t = 0; t < 36; t++) begin
            cycle(4'b1111, PAT);
            check("fair_grant", 32'(bus.grant), (t % 9 == 8) ? 32'd0 : 32'(1) << ((t / 9) % 4));
        end
        do_reset();
        r = '0;
        for (int t = 0; t < 3000; t++) begin
            for (int b = 0; b < NREQ; b++)
                if ($urandom_range(7) == 0) r[b] = ~r[b];
            cycle(r, (NREQ*BITS)'($urandom));
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
